// File: rtl/sync_shift_reg_filter.sv
// Multi-channel DEPTH-stage synchronizer with optional per-bit stability filter and edge pulses.
// Define SYNC_SHIFT_REG_FILTER_STATS_EN to add the saturating rejected-glitch counter (io_glitch_count).
module sync_shift_reg_filter #(
   parameter int               WIDTH  = 1,
   parameter int               DEPTH  = 3,
   parameter logic [WIDTH-1:0] INIT   = '0,
   parameter int               FILTER = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] io_d,
   output logic [WIDTH-1:0] io_q,
   output logic [WIDTH-1:0] io_rise,
   output logic [WIDTH-1:0] io_fall
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
   ,
   output logic [7:0]       io_glitch_count
`endif
);

   genvar gi;

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_shift_reg_filter: DEPTH must be >= 2");
   end
   if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
      $error("sync_shift_reg_filter: FILTER must be in 0..255");
   end

   // Stage DEPTH-1 captures io_d; stage 0 is the only tap used downstream.
   logic [DEPTH-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]            sync0;
   logic [WIDTH-1:0]            filt;
   logic [WIDTH-1:0]            prev_q;
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
   logic [WIDTH-1:0]            rej_vec;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= {DEPTH{INIT}};
      end else begin
         sync_q <= {io_d, sync_q[DEPTH-1:1]};
      end
   end

   assign sync0 = sync_q[0];

   if (FILTER == 0) begin : g_bypass
      assign filt = sync0;
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      assign rej_vec = '0;
`endif
   end else begin : g_filter
      localparam int            CW       = $clog2(FILTER + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CW-1:0] cnt_q, cnt_d;
         logic          bit_q, bit_d;

         always_comb begin
            cnt_d = cnt_q;
            bit_d = bit_q;
            if (sync0[gi] == bit_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               bit_d = sync0[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               cnt_q <= '0;
               bit_q <= INIT[gi];
            end else begin
               cnt_q <= cnt_d;
               bit_q <= bit_d;
            end
         end

         assign filt[gi] = bit_q;
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
         // A pending run that collapses back to the held level is a rejected glitch.
         assign rej_vec[gi] = (sync0[gi] == bit_q) && (cnt_q != '0);
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= INIT;
      end else begin
         prev_q <= filt;
      end
   end

   assign io_q    = filt;
   assign io_rise = filt & ~prev_q;
   assign io_fall = ~filt & prev_q;

`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
   logic [7:0]  gc_q, gc_d;
   logic [31:0] gc_sum;

   always_comb begin
      gc_sum = 32'(gc_q);
      for (int i = 0; i < WIDTH; i++) begin
         gc_sum = gc_sum + 32'(rej_vec[i]);
      end
      gc_d = (gc_sum > 32'd255) ? 8'd255 : gc_sum[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gc_q <= '0;
      end else begin
         gc_q <= gc_d;
      end
   end

   assign io_glitch_count = gc_q;
`endif

endmodule

// File: tb/tb_sync_shift_reg_filter.sv
// Scoreboard bench: four configurations share one clock; a per-cycle reference queue is compared at negedge.
module tb_sync_shift_reg_filter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [3:0] rst;
   logic [0:0] d0, q0, r0, f0;
   logic [3:0] d1, q1, r1, f1;
   logic [0:0] d2, q2, r2, f2;
   logic [7:0] d3, q3, r3, f3;
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
   logic [7:0] gc0, gc1, gc2, gc3;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sync_shift_reg_filter #(.WIDTH(1), .DEPTH(3), .INIT(1'b0), .FILTER(0)) u0 (
      .clock(clock), .reset(rst[0]), .io_d(d0), .io_q(q0), .io_rise(r0), .io_fall(f0)
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      , .io_glitch_count(gc0)
`endif
   );
   sync_shift_reg_filter #(.WIDTH(4), .DEPTH(2), .INIT(4'b1010), .FILTER(0)) u1 (
      .clock(clock), .reset(rst[1]), .io_d(d1), .io_q(q1), .io_rise(r1), .io_fall(f1)
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      , .io_glitch_count(gc1)
`endif
   );
   sync_shift_reg_filter #(.WIDTH(1), .DEPTH(3), .INIT(1'b0), .FILTER(4)) u2 (
      .clock(clock), .reset(rst[2]), .io_d(d2), .io_q(q2), .io_rise(r2), .io_fall(f2)
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      , .io_glitch_count(gc2)
`endif
   );
   sync_shift_reg_filter #(.WIDTH(8), .DEPTH(3), .INIT(8'h00), .FILTER(2)) u3 (
      .clock(clock), .reset(rst[3]), .io_d(d3), .io_q(q3), .io_rise(r3), .io_fall(f3)
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      , .io_glitch_count(gc3)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int pw(input int k);
      case (k) 0: return 1; 1: return 4; 2: return 1; default: return 8; endcase
   endfunction
   function automatic int pd(input int k);
      case (k) 1: return 2; default: return 3; endcase
   endfunction
   function automatic int pf(input int k);
      case (k) 2: return 4; 3: return 2; default: return 0; endcase
   endfunction
   function automatic logic [7:0] pinit(input int k);
      case (k) 1: return 8'h0A; default: return 8'h00; endcase
   endfunction
   function automatic logic [7:0] get_d(input int k);
      case (k) 0: return {7'b0, d0}; 1: return {4'b0, d1}; 2: return {7'b0, d2}; default: return d3; endcase
   endfunction

   task automatic get_obs(input int k, output logic [7:0] oq, output logic [7:0] orr,
                          output logic [7:0] of, output logic [7:0] og);
      og = 8'h00;
      case (k)
         0: begin oq = {7'b0, q0}; orr = {7'b0, r0}; of = {7'b0, f0};
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
            og = gc0;
`endif
         end
         1: begin oq = {4'b0, q1}; orr = {4'b0, r1}; of = {4'b0, f1};
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
            og = gc1;
`endif
         end
         2: begin oq = {7'b0, q2}; orr = {7'b0, r2}; of = {7'b0, f2};
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
            og = gc2;
`endif
         end
         default: begin oq = q3; orr = r3; of = f3;
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
            og = gc3;
`endif
         end
      endcase
   endtask

   // Reference state: m_sync[k][0] is the oldest sample, i.e. the synchronized value.
   logic [7:0] m_sync [4][3];
   logic [7:0] m_q    [4];
   logic [7:0] m_qp   [4];
   int         m_cnt  [4][8];
   int         m_gc   [4];

   typedef struct {
      int         k;
      logic [7:0] q;
      logic [7:0] rise;
      logic [7:0] fall;
      int         gc;
   } exp_t;
   exp_t sb[$];

   task automatic model_step(input int k, input logic r, input logic [7:0] din);
      int         w, dd, f;
      logic [7:0] mask, s0, vis;
      exp_t       e;
      w = pw(k); dd = pd(k); f = pf(k);
      mask = 8'((1 << w) - 1);
      if (r) begin
         for (int s = 0; s < 3; s++) m_sync[k][s] = pinit(k);
         m_q[k]  = pinit(k);
         m_qp[k] = pinit(k);
         for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
         m_gc[k] = 0;
      end else begin
         s0 = m_sync[k][0];
         m_qp[k] = (f == 0) ? s0 : m_q[k];
         if (f > 0) begin
            for (int i = 0; i < w; i++) begin
               if (s0[i] == m_q[k][i]) begin
                  if (m_cnt[k][i] != 0 && m_gc[k] < 255) m_gc[k]++;
                  m_cnt[k][i] = 0;
               end else if (m_cnt[k][i] == f - 1) begin
                  m_q[k][i]   = s0[i];
                  m_cnt[k][i] = 0;
               end else begin
                  m_cnt[k][i]++;
               end
            end
         end
         for (int s = 0; s < dd - 1; s++) m_sync[k][s] = m_sync[k][s+1];
         m_sync[k][dd-1] = din & mask;
      end
      vis    = (f == 0) ? m_sync[k][0] : m_q[k];
      e.k    = k;
      e.q    = vis;
      e.rise = vis & ~m_qp[k];
      e.fall = ~vis & m_qp[k] & mask;
      e.gc   = m_gc[k];
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t       e;
      logic [7:0] oq, orr, of, og;
      for (int k = 0; k < 4; k++) model_step(k, rst[k], get_d(k));
      @(posedge clock);
      @(negedge clock);
      cyc++;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         get_obs(e.k, oq, orr, of, og);
         check_val($sformatf("c%0d u%0d q", cyc, e.k), 32'(oq), 32'(e.q));
         check_val($sformatf("c%0d u%0d rise", cyc, e.k), 32'(orr), 32'(e.rise));
         check_val($sformatf("c%0d u%0d fall", cyc, e.k), 32'(of), 32'(e.fall));
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
         check_val($sformatf("c%0d u%0d gcount", cyc, e.k), 32'(og), 32'(e.gc));
`endif
      end
   endtask

   int n;
   int rises;
   logic saw;

   initial begin
      rst = 4'hF;
      d0 = 1'b0; d1 = 4'b0101; d2 = 1'b0; d3 = 8'h00;

      // Reset held two cycles; outputs must sit at INIT with no pulses.
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("rst u1 q", 32'(q1), 32'h0A);
         check_val("rst u1 pulses", 32'({r1, f1}), 32'h00);
      end
      rst = 4'h0;

      // u0: 0->1 step, u1: INIT 1010 -> io_d 0101.
      d0 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 2) begin
            check_val("t2 q", 32'(q1), 32'h5);
            check_val("t2 rise", 32'(r1), 32'h5);
            check_val("t2 fall", 32'(f1), 32'hA);
         end
         if (i == 3) begin
            check_val("t1 q edge3", 32'(q0), 32'h1);
            check_val("t1 rise edge3", 32'(r0), 32'h1);
            check_val("t2 pulse gone", 32'({r1, f1}), 32'h00);
         end
         if (i == 4) check_val("t1 rise once", 32'(r0), 32'h0);
         if (i == 2) check_val("t1 q edge2", 32'(q0), 32'h0);
      end

      // u2: three-cycle high pulse is shorter than FILTER and must be rejected.
      saw = 1'b0;
      d2 = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); saw = saw | q2[0] | r2[0]; end
      d2 = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); saw = saw | q2[0] | r2[0]; end
      check_val("t3 rejected", 32'(saw), 32'h0);
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      check_val("t3 gcount", 32'(gc2), 32'd1);
`endif

      // u2: clean step appears after DEPTH+FILTER edges with one rise pulse.
      d2 = 1'b1;
      rises = 0;
      for (n = 1; n <= 20; n++) begin
         tick();
         rises += int'(r2[0]);
         if (q2[0]) break;
      end
      check_val("t4 latency", 32'(n), 32'd7);
      for (int i = 0; i < 5; i++) begin tick(); rises += int'(r2[0]); end
      check_val("t4 rise count", 32'(rises), 32'd1);

      // u2: reset lands before the filter completes; full latency applies again.
      d2 = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      d2 = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rst[2] = 1'b1;
      tick();
      check_val("t5 q in reset", 32'(q2), 32'h0);
      check_val("t5 pulses in reset", 32'({r2, f2}), 32'h0);
      rst[2] = 1'b0;
      for (n = 1; n <= 20; n++) begin
         tick();
         if (q2[0]) break;
      end
      check_val("t5 latency", 32'(n), 32'd7);

      // u3: 40 single-cycle glitches on all 8 bits.
      saw = 1'b0;
      for (int g = 0; g < 40; g++) begin
         d3 = 8'hFF;
         tick(); saw = saw | (|q3);
         d3 = 8'h00;
         for (int i = 0; i < 3; i++) begin tick(); saw = saw | (|q3); end
      end
      check_val("t6 q unchanged", 32'(saw), 32'h0);
`ifdef SYNC_SHIFT_REG_FILTER_STATS_EN
      check_val("t6 gcount sat", 32'(gc3), 32'd255);
      for (int i = 0; i < 3; i++) tick();
      check_val("t6 gcount hold", 32'(gc3), 32'd255);
`endif

      // Random traffic on every channel of every instance.
      for (int i = 0; i < 80; i++) begin
         d0 = 1'($urandom_range(0, 1));
         d1 = 4'($urandom);
         d2 = (i % 9 < 5) ? 1'b1 : 1'b0;
         d3 = 8'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
